pmp_merge_sched: RTL and testbench

//  Synchronous scheduler that shares one 64-bit PMP merge buffer between NUM_REQ requesters in the MMU.

---
 rtl/pmp_merge_pkg.sv | 13 +
 rtl/pmp_rr_arb.sv | 33 +++
 rtl/pmp_merge_sched.sv | 156 +++++++++++++++
 tb/tb_pmp_merge_sched.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_merge_pkg.sv
// Shared types and widths for the PMP merge scheduler.
package pmp_merge_pkg;

  localparam int PMP_HALF_W = 32;
  localparam int PMP_WORD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2
  } pmp_state_e;

endpackage

// File: rtl/pmp_rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping at NUM_REQ.
module pmp_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W:0]       off;
  logic [IDX_W:0]       sum;

  // Rotating a doubled copy puts the pointer at bit 0, so the lowest set bit is the winner.
  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDX_W+1)'(i);
    end
    sum = {1'b0, ptr_i} + off;
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    any_o   = |req_i;
    idx_o   = sum[IDX_W-1:0];
    grant_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/pmp_merge_sched.sv
// Shares one 64-bit PMP merge buffer between NUM_REQ requesters: lock an owner, pair {hi,lo}, issue downstream.
// Handshake: a transfer happens on a cycle where valid and ready are both high; the sender holds its payload until then.
module pmp_merge_sched import pmp_merge_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              i_valid,
  input  logic [NUM_REQ-1:0]              i_hi,
  input  logic [NUM_REQ*PMP_HALF_W-1:0]   i_data_32,
  output logic [NUM_REQ-1:0]              o_ready,
  output logic                            o_valid,
  output logic [PMP_WORD_W-1:0]           o_data_64,
  output logic [IDX_W-1:0]                o_src,
  input  logic                            i_ready,
  output logic                            o_busy,
  output logic                            o_timeout
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  pmp_state_e            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic                  have_lo_q, have_lo_d;
  logic                  have_hi_q, have_hi_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [PMP_WORD_W-1:0] buf_q, buf_d;
  logic                  tmo_q, tmo_d;

  logic [NUM_REQ-1:0]    gnt_vec;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic [IDX_W-1:0]      sel;
  logic                  sel_hi;
  logic [PMP_HALF_W-1:0] sel_data;
  logic                  acc;
  logic [IDX_W-1:0]      owner_nxt;

  pmp_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (i_valid),
    .ptr_i   (ptr_q),
    .grant_o (gnt_vec),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  always_comb begin
    o_ready = '0;
    case (state_q)
      ST_IDLE:    o_ready = gnt_vec;
      ST_COLLECT: o_ready = NUM_REQ'(1) << owner_q;
      default:    o_ready = '0;
    endcase
  end

  always_comb begin
    sel      = (state_q == ST_IDLE) ? gnt_idx : owner_q;
    sel_hi   = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == IDX_W'(k)) begin
        sel_hi   = i_hi[k];
        sel_data = i_data_32[k*PMP_HALF_W +: PMP_HALF_W];
      end
    end
    acc       = gnt_any && |(i_valid & o_ready);
    owner_nxt = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    have_lo_d = have_lo_q;
    have_hi_d = have_hi_q;
    timer_d   = timer_q;
    buf_d     = buf_q;
    tmo_d     = 1'b0;

    if (acc) begin
      if (sel_hi) buf_d[PMP_WORD_W-1:PMP_HALF_W] = sel_data;
      else        buf_d[PMP_HALF_W-1:0]          = sel_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          owner_d   = gnt_idx;
          have_lo_d = ~sel_hi;
          have_hi_d = sel_hi;
          timer_d   = '0;
          state_d   = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // A repeated half overwrites the held one and restarts the abandonment timer.
        if (acc) begin
          timer_d = '0;
          if (sel_hi) have_hi_d = 1'b1;
          else        have_lo_d = 1'b1;
          if (have_lo_d && have_hi_d) state_d = ST_SEND;
        end else if (TIMEOUT != 0 && timer_q == TMR_W'(TIMEOUT - 1)) begin
          tmo_d     = 1'b1;
          have_lo_d = 1'b0;
          have_hi_d = 1'b0;
          timer_d   = '0;
          ptr_d     = owner_nxt;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (i_ready) begin
          ptr_d     = owner_nxt;
          have_lo_d = 1'b0;
          have_hi_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      have_lo_q <= 1'b0;
      have_hi_q <= 1'b0;
      timer_q   <= '0;
      buf_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      have_lo_q <= have_lo_d;
      have_hi_q <= have_hi_d;
      timer_q   <= timer_d;
      buf_q     <= buf_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_valid   = (state_q == ST_SEND);
  assign o_data_64 = buf_q;
  assign o_src     = owner_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_timeout = tmo_q;

endmodule

// File: tb/tb_pmp_merge_sched.sv
// Bench for pmp_merge_sched: directed steps plus a randomized multi-requester run against a word-level model.
module tb_pmp_merge_sched;

  localparam int N   = 3;
  localparam int TMO = 16;
  localparam int IW  = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_valid, i_hi, o_ready;
  logic [N*32-1:0] i_data_32;
  logic            o_valid;
  logic [63:0]     o_data_64;
  logic [IW-1:0]   o_src;
  logic            i_ready, o_busy, o_timeout;

  logic            drv_vld[N];
  logic            drv_hi[N];
  logic [31:0]     drv_dat[N];

  int n_tests = 0;
  int n_fail  = 0;

  // Word-level model: per-requester half streams, expected words, round-robin pointer.
  logic [31:0] hq_dat[N][$];
  logic        hq_hi[N][$];
  int          wq_halves[N][$];
  logic [63:0] exp_q[N][$];
  int          order_q[$];
  int          ptr_m, cur_own, halves_left;
  bit          in_word, word_done;

  pmp_merge_sched #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_hi      (i_hi),
    .i_data_32 (i_data_32),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_data_64 (o_data_64),
    .o_src     (o_src),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      i_valid[k]           = drv_vld[k];
      i_hi[k]              = drv_hi[k];
      i_data_32[k*32 +: 32] = drv_dat[k];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic hi, input logic [31:0] d);
    drv_vld[k] = 1'b1;
    drv_hi[k]  = hi;
    drv_dat[k] = d;
  endtask

  task automatic clr_in();
    for (int k = 0; k < N; k++) begin
      drv_vld[k] = 1'b0;
      drv_hi[k]  = 1'b0;
      drv_dat[k] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_ready = 1'b0;
    clr_in();
    tick();
    tick();
    rst = 1'b0;
    ptr_m = 0;
    cur_own = -1;
    in_word = 1'b0;
    word_done = 1'b0;
    halves_left = 0;
  endtask

  task automatic send_pair(input int k, input logic [31:0] lo, input logic [31:0] hi);
    set_req(k, 1'b0, lo);
    tick();
    set_req(k, 1'b1, hi);
    tick();
    clr_in();
  endtask

  task automatic add_word(input int k, input logic [31:0] lo, input logic [31:0] hi,
                          input bit hi_first, input bit dup);
    logic [31:0] fd, sd;
    int n;
    fd = hi_first ? hi : lo;
    sd = hi_first ? lo : hi;
    n = 2;
    if (dup) begin
      hq_hi[k].push_back(hi_first);
      hq_dat[k].push_back(~fd);
      n = 3;
    end
    hq_hi[k].push_back(hi_first);
    hq_dat[k].push_back(fd);
    hq_hi[k].push_back(!hi_first);
    hq_dat[k].push_back(sd);
    wq_halves[k].push_back(n);
    exp_q[k].push_back({hi, lo});
  endtask

  task automatic run_engine(input int max_cyc, input int rdy_pct);
    int cyc, left, j, e, pk;
    logic [N-1:0] acc;
    bit hs;
    cyc = 0;
    while (1) begin
      left = 0;
      for (int k = 0; k < N; k++) left += exp_q[k].size();
      if (left == 0) break;
      if (cyc >= max_cyc) begin
        chk("eng_budget_words_left", left, 0);
        break;
      end
      for (int k = 0; k < N; k++) begin
        if (hq_dat[k].size() > 0) set_req(k, hq_hi[k][0], hq_dat[k][0]);
        else begin
          drv_vld[k] = 1'b0;
          drv_hi[k]  = 1'b0;
          drv_dat[k] = '0;
        end
      end
      i_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      chk("eng_valid", o_valid, in_word && word_done);
      chk("eng_timeout", o_timeout, 0);
      if (o_valid && in_word && word_done) begin
        chk("eng_src", o_src, cur_own);
        chk("eng_data", o_data_64, exp_q[cur_own][0]);
        chk("eng_ready_in_send", o_ready, 0);
      end
      acc = i_valid & o_ready;
      hs = o_valid && i_ready && in_word && word_done;
      if (acc != '0) begin
        chk("eng_onehot_accept", $countones(acc), 1);
        j = -1;
        for (int k = N - 1; k >= 0; k--) if (acc[k]) j = k;
        if (!in_word) begin
          e = -1;
          for (int s = 0; s < N; s++) begin
            pk = (ptr_m + s) % N;
            if (e < 0 && exp_q[pk].size() > 0) e = pk;
          end
          chk("eng_grant", j, e);
          order_q.push_back(j);
          in_word = 1'b1;
          cur_own = j;
          halves_left = (wq_halves[j].size() > 0) ? wq_halves[j][0] - 1 : 0;
          word_done = (halves_left == 0);
        end else begin
          chk("eng_owner", j, cur_own);
          if (j == cur_own) begin
            halves_left--;
            word_done = (halves_left == 0);
          end
        end
        if (hq_dat[j].size() > 0) begin
          void'(hq_dat[j].pop_front());
          void'(hq_hi[j].pop_front());
        end
      end
      if (hs) begin
        void'(exp_q[cur_own].pop_front());
        void'(wq_halves[cur_own].pop_front());
        ptr_m = (cur_own + 1) % N;
        in_word = 1'b0;
        word_done = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    clr_in();
    i_ready = 1'b0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    i_ready = 1'b0;
    clr_in();
    tick();
    tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_data", o_data_64, 64'h0);
    rst = 1'b0;
    tick();
    chk("idle_busy", o_busy, 0);
    chk("idle_ready", o_ready, 0);

    // Basic lo then hi from req0.
    i_ready = 1'b1;
    set_req(0, 1'b0, 32'h1111_1111);
    #1 chk("t1_ready_lo", o_ready, 3'b001);
    tick();
    set_req(0, 1'b1, 32'h2222_2222);
    #1 chk("t1_busy", o_busy, 1);
    chk("t1_no_valid_yet", o_valid, 0);
    chk("t1_ready_hi", o_ready, 3'b001);
    tick();
    clr_in();
    #1 chk("t1_valid", o_valid, 1);
    chk("t1_data", o_data_64, 64'h2222_2222_1111_1111);
    chk("t1_src", o_src, 0);
    chk("t1_ready_send", o_ready, 0);
    tick();
    chk("t1_valid_drop", o_valid, 0);
    chk("t1_busy_drop", o_busy, 0);

    // Repeated lo: last one wins; pointer has moved to req1.
    set_req(1, 1'b0, 32'h0000_000A);
    #1 chk("t1b_ready", o_ready, 3'b010);
    tick();
    set_req(1, 1'b0, 32'h0000_000B);
    tick();
    set_req(1, 1'b1, 32'hCCCC_CCCC);
    tick();
    clr_in();
    #1 chk("t1b_data", o_data_64, 64'hCCCC_CCCC_0000_000B);
    chk("t1b_src", o_src, 1);
    tick();

    // Two requesters under load alternate.
    do_reset();
    order_q.delete();
    add_word(0, 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
    add_word(0, 32'h0303_0303, 32'h0404_0404, 1'b0, 1'b0);
    add_word(1, 32'h1010_1010, 32'h2020_2020, 1'b0, 1'b0);
    add_word(1, 32'h3030_3030, 32'h4040_4040, 1'b0, 1'b0);
    run_engine(200, 100);
    chk("t2_words", order_q.size(), 4);
    for (int i = 0; i < order_q.size() && i < 4; i++) chk("t2_order", order_q[i], i % 2);

    // Abandoned hi from req1 times out 16 cycles after accept.
    do_reset();
    set_req(1, 1'b1, 32'h4444_4444);
    #1 chk("t3_ready", o_ready, 3'b010);
    tick();
    clr_in();
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("t3_timeout", o_timeout, (k == 16));
      chk("t3_busy", o_busy, (k < 16));
    end
    set_req(0, 1'b0, 32'h1);
    set_req(1, 1'b0, 32'h2);
    #1 chk("t3_next_grant", o_ready, 3'b001);
    clr_in();

    // Overwriting lo restarts the timer.
    do_reset();
    set_req(0, 1'b0, 32'h0000_000A);
    tick();
    clr_in();
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (o_timeout) pulses++;
    end
    set_req(0, 1'b0, 32'h0000_000B);
    #1 chk("t4_ready_again", o_ready, 3'b001);
    tick();
    clr_in();
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) chk("t4_timeout_at_16", o_timeout, 1);
      else if (o_timeout) pulses++;
    end
    chk("t4_early_pulses", pulses, 0);
    set_req(0, 1'b1, 32'hCCCC_0000);
    tick();
    clr_in();
    tick();
    chk("t4_halves_cleared", o_valid, 0);

    // Accept on the expiry cycle wins, then a 5-cycle downstream stall.
    do_reset();
    set_req(0, 1'b0, 32'h5555_5555);
    tick();
    clr_in();
    for (int k = 1; k <= 15; k++) tick();
    set_req(0, 1'b1, 32'h6666_6666);
    tick();
    clr_in();
    set_req(1, 1'b0, 32'h0000_0007);
    #1 chk("t4b_no_timeout", o_timeout, 0);
    for (int k = 0; k < 5; k++) begin
      chk("t5_valid", o_valid, 1);
      chk("t5_data", o_data_64, 64'h6666_6666_5555_5555);
      chk("t5_src", o_src, 0);
      chk("t5_ready", o_ready, 0);
      tick();
    end
    i_ready = 1'b1;
    tick();
    chk("t5_released", o_valid, 0);
    chk("t5_next_owner", o_ready, 3'b010);
    chk("t5_no_timeout", o_timeout, 0);
    clr_in();
    i_ready = 1'b0;

    // Reset while collecting drops the held half and never times out.
    do_reset();
    set_req(2, 1'b0, 32'h0BAD_0001);
    #1 chk("t6_grant2", o_ready, 3'b100);
    tick();
    clr_in();
    rst = 1'b1;
    tick();
    chk("t6c_valid", o_valid, 0);
    chk("t6c_busy", o_busy, 0);
    chk("t6c_timeout", o_timeout, 0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_timeout) pulses++;
    end
    chk("t6c_no_pulse", pulses, 0);
    set_req(1, 1'b1, 32'h8888_8888);
    tick();
    clr_in();
    tick();
    chk("t6c_no_stale_half", o_valid, 0);

    // Reset while sending returns the pointer to 0 and leaves no stale word.
    do_reset();
    i_ready = 1'b1;
    set_req(1, 1'b0, 32'h1);
    #1;
    clr_in();
    set_req(1, 1'b0, 32'h1);
    send_pair(1, 32'h1, 32'h2);
    tick();
    i_ready = 1'b0;
    send_pair(0, 32'h3, 32'h4);
    #1 chk("t6s_in_send", o_valid, 1);
    rst = 1'b1;
    tick();
    chk("t6s_valid", o_valid, 0);
    chk("t6s_busy", o_busy, 0);
    chk("t6s_timeout", o_timeout, 0);
    rst = 1'b0;
    i_ready = 1'b1;
    set_req(1, 1'b0, 32'h5);
    set_req(2, 1'b0, 32'h6);
    #1 chk("t6s_ptr0", o_ready, 3'b010);
    clr_in();
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_valid) pulses++;
    end
    chk("t6s_no_stale_word", pulses, 0);

    // Randomized run with random half order, repeated halves and downstream back-pressure.
    do_reset();
    for (int k = 0; k < N; k++) begin
      for (int w = 0; w < 8 + 3 * k; w++) begin
        add_word(k, $urandom, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end
    end
    run_engine(3000, 70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
